// File: rtl/controlador_displays.sv
// Four-digit seven-segment scan controller with frame-synchronous digit update.
// Optional leading-zero blanking on digits 3..1 when ZERO_SUPPRESS_EN is defined.
module controlador_displays #(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digitos,
  input  logic [3:0]  pontos,
  output logic        ready,
  output logic [3:0]  displays,
  output logic [7:0]  segmentos,
  output logic        frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic [15:0]   act_d, act_d_n, sh_d, sh_d_n;
  logic [3:0]    act_p, act_p_n, sh_p, sh_p_n;
  logic          pend, pend_n;
  logic          slot_end, boundary, accept, lit, zblank;
  logic [3:0]    zs;
  logic [3:0]    cur;
  logic [3:0]    disp_n;
  logic [7:0]    seg_n;
  logic          fd_n;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  // Outputs are registered from the post-edge state so they stay aligned with
  // the counters: the boundary edge shows the freshly applied active set.
  always_comb begin
    slot_end = (cnt == LAST);
    boundary = slot_end && (idx == 2'd3);
    accept   = load && !pend;
    cnt_n    = slot_end ? '0 : cnt + 1'b1;
    idx_n    = slot_end ? idx + 2'd1 : idx;
    act_d_n  = act_d;
    act_p_n  = act_p;
    sh_d_n   = sh_d;
    sh_p_n   = sh_p;
    pend_n   = pend;
    if (boundary) begin
      if (pend) begin
        act_d_n = sh_d;
        act_p_n = sh_p;
        pend_n  = 1'b0;
      end else if (accept) begin
        act_d_n = digitos;
        act_p_n = pontos;
      end
    end else if (accept) begin
      sh_d_n = digitos;
      sh_p_n = pontos;
      pend_n = 1'b1;
    end

    fd_n = (cnt_n == LAST) && (idx_n == 2'd3);
    lit  = !(int'(cnt_n) < DEAD);
    cur  = act_d_n[idx_n*4 +: 4];

    zs = '0;
`ifdef ZERO_SUPPRESS_EN
    zs[3] = (act_d_n[15:12] == 4'd0);
    zs[2] = zs[3] && (act_d_n[11:8] == 4'd0);
    zs[1] = zs[2] && (act_d_n[7:4] == 4'd0);
`endif
    zblank = zs[idx_n];

    disp_n = '0;
    seg_n  = '0;
    if (lit) begin
      disp_n = 4'b0001 << idx_n;
      seg_n  = {act_p_n[idx_n], zblank ? 7'h00 : seg7(cur)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      act_d      <= '0;
      act_p      <= '0;
      sh_d       <= '0;
      sh_p       <= '0;
      pend       <= 1'b0;
      ready      <= 1'b1;
      displays   <= '0;
      segmentos  <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      act_d      <= act_d_n;
      act_p      <= act_p_n;
      sh_d       <= sh_d_n;
      sh_p       <= sh_p_n;
      pend       <= pend_n;
      ready      <= !pend_n;
      displays   <= disp_n;
      segmentos  <= seg_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_controlador_displays.sv
// Self-checking bench for controlador_displays: directed steps plus random loads
// checked every cycle against a frame-arithmetic reference model.
module tb_controlador_displays;

  localparam int P = 4;
  localparam int D = 1;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digitos = '0;
  logic [3:0]  pontos = '0;
  logic        ready;
  logic [3:0]  displays;
  logic [7:0]  segmentos;
  logic        frame_done;

  controlador_displays #(.PRESCALE(P), .DEAD(D)) dut (
    .clk(clk), .rst(rst), .load(load), .digitos(digitos), .pontos(pontos),
    .ready(ready), .displays(displays), .segmentos(segmentos), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state: cycle index since reset, active/shadow sets
  int          m_t;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_pts, m_shp;
  bit          m_pend;
  logic [6:0]  tbl[16];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0d: got %h expected %h", tag, m_t, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_act = '0; m_sh = '0; m_pts = '0; m_shp = '0; m_pend = 0;
  endtask

  task automatic check_now();
    int d, pos;
    logic [3:0] v;
    logic [3:0] e_disp;
    logic [7:0] e_seg;
    bit sup;
    pos = m_t % P;
    d   = (m_t / P) % 4;
    v   = m_act[4*d +: 4];
`ifdef ZERO_SUPPRESS_EN
    sup = (d > 0) && ((m_act >> (4 * d)) == 16'd0);
`else
    sup = 0;
`endif
    e_disp = '0;
    e_seg  = '0;
    if (pos >= D) begin
      e_disp = 4'(1 << d);
      e_seg  = {m_pts[d], sup ? 7'h00 : tbl[v]};
    end
    chk("displays", {4'h0, displays}, {4'h0, e_disp});
    chk("segmentos", segmentos, e_seg);
    chk("frame_done", {7'h0, frame_done}, {7'h0, (m_t % FRAME) == FRAME - 1});
    chk("ready", {7'h0, ready}, {7'h0, !m_pend});
  endtask

  // one cycle: check, present inputs, apply the edge to the model
  task automatic step(input logic ld, input logic [15:0] dg, input logic [3:0] pt);
    bit last;
    check_now();
    load = ld; digitos = dg; pontos = pt;
    last = (m_t % FRAME) == FRAME - 1;
    if (last) begin
      if (m_pend) begin
        m_act = m_sh; m_pts = m_shp; m_pend = 0;
      end else if (ld) begin
        m_act = dg; m_pts = pt;
      end
    end else if (ld && !m_pend) begin
      m_sh = dg; m_shp = pt; m_pend = 1;
    end
    @(posedge clk);
    m_t++;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (m_t % FRAME) != phase; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    logic [15:0] rd;
    tbl[0] = 7'h3F; tbl[1] = 7'h06; tbl[2] = 7'h5B; tbl[3] = 7'h4F;
    tbl[4] = 7'h66; tbl[5] = 7'h6D; tbl[6] = 7'h7D; tbl[7] = 7'h07;
    tbl[8] = 7'h7F; tbl[9] = 7'h6F;
    for (int i = 10; i < 16; i++) tbl[i] = 7'h40;

    // reset state
    model_reset();
    @(negedge clk);
    chk("rst_displays", {4'h0, displays}, 8'h00);
    chk("rst_segmentos", segmentos, 8'h00);
    chk("rst_frame_done", {7'h0, frame_done}, 8'h00);
    chk("rst_ready", {7'h0, ready}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // idle scan of all-zero digits
    idle(40);

    // load mid-slot 1, then a second load while busy
    run_to(5);
    step(1'b1, 16'h1234, 4'b0100);
    step(1'b1, 16'h9999, 4'b1111);
    idle(40);

    // load exactly on the frame-boundary edge
    run_to(FRAME - 1);
    step(1'b1, 16'h5678, 4'b0001);
    idle(20);

    // dash and leading-zero case
    run_to(3);
    step(1'b1, 16'h00A7, 4'b0000);
    idle(36);

    // random loads
    for (int i = 0; i < 400; i++) begin
      rd = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rd = rd & 16'h00FF;
        1: rd = rd & 16'h0F0F;
        2: rd = rd & 16'h000F;
        default: ;
      endcase
      step(($urandom_range(0, 3) == 0), rd, 4'($urandom));
    end

    // asynchronous reset during slot 2 with a load pending
    run_to(2);
    step(1'b1, 16'h4321, 4'b1010);
    run_to(9);
    #1 rst = 1'b1;
    #1;
    chk("arst_displays", {4'h0, displays}, 8'h00);
    chk("arst_segmentos", segmentos, 8'h00);
    chk("arst_frame_done", {7'h0, frame_done}, 8'h00);
    chk("arst_ready", {7'h0, ready}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
